// File: rtl/multicycle_controller_if.sv
// Datapath control bundle between the RISC24 multicycle sequencer (master)
// and the datapath it drives (slave).
interface multicycle_controller_if;
  logic [3:0] opcode;
  logic [1:0] funct;
  logic       alu_zero;
  logic       alu_carry;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_ctrl;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic [1:0] wb_sel;
  logic       carry_flag;
  logic       zero_flag;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, alu_zero, alu_carry, mem_ready,
    output ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
           mem_read, mem_write, reg_write, reg_dst, wb_sel,
           carry_flag, zero_flag, illegal, state
  );

  modport slave (
    output opcode, funct, alu_zero, alu_carry, mem_ready,
    input  ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl,
           mem_read, mem_write, reg_write, reg_dst, wb_sel,
           carry_flag, zero_flag, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the RISC24 datapath: fetch/decode/execute/memory/
// writeback stepping, datapath strobes, architectural C/Z flags.
// Optional build macro RISC24_ILLEGAL_HALT_EN: an illegal opcode parks the
// sequencer in HALT until reset instead of retiring as a NOP.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read IR at PC, PC <= PC+1 (stalls on mem_ready)
// DECODE    | ALUOut <= PC + sext imm (target), dispatch on opcode
// EXEC_R    | regA op regB, update flags
// WB_R      | write ALUOut to rc
// EXEC_ADDR | ALUOut <= regA + sext imm6
// MEM_RD    | read MDR (stalls on mem_ready)
// WB_MEM    | write MDR to ra
// MEM_WR    | store regB (stalls on mem_ready)
// BRANCH    | compare regA-regB, PC <= ALUOut if equal
// JAL       | ra <= PC, PC <= ALUOut
// HALT      | dead stop after illegal opcode (macro builds only)
module multicycle_controller (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_WB_R      = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM_RD    = 4'd5,
    S_WB_MEM    = 4'd6,
    S_MEM_WR    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JAL       = 4'd9
`ifdef RISC24_ILLEGAL_HALT_EN
    , S_HALT    = 4'd15
`endif
  } state_t;

  state_t state_q, state_d;
  logic   carry_q, zero_q;

  logic op_add, op_ndu, op_lw, op_sw, op_beq, op_jal;
  logic r_type, op_legal, cond_ok;

  logic       ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0] alu_src_b, alu_ctrl, wb_sel;
  logic       mem_read, mem_write, reg_write, reg_dst, illegal;

  // Opcode classification and the conditional-execute predicate
  always_comb begin
    op_add   = (bus.opcode == 4'b0000);
    op_ndu   = (bus.opcode == 4'b0010);
    op_lw    = (bus.opcode == 4'b0100);
    op_sw    = (bus.opcode == 4'b0101);
    op_beq   = (bus.opcode == 4'b1100);
    op_jal   = (bus.opcode == 4'b1000);
    r_type   = (op_add || op_ndu) && (bus.funct != 2'b11);
    op_legal = r_type || op_lw || op_sw || op_beq || op_jal;
    case (bus.funct)
      2'b00:   cond_ok = 1'b1;
      2'b10:   cond_ok = carry_q;
      2'b01:   cond_ok = zero_q;
      default: cond_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Architectural flags: written only when leaving EXEC_R
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (state_q == S_EXEC_R) begin
      zero_q <= bus.alu_zero;
      if (op_add) carry_q <= bus.alu_carry;
    end
  end

  // Next-state and strobe decode; reset forces every output low
  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctrl  = 2'b00;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 2'b00;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = op_jal ? 2'b11 : 2'b10;
        if (r_type)               state_d = cond_ok ? S_EXEC_R : S_FETCH;
        else if (op_lw || op_sw)  state_d = S_EXEC_ADDR;
        else if (op_beq)          state_d = S_BRANCH;
        else if (op_jal)          state_d = S_JAL;
        else begin
          illegal = 1'b1;
`ifdef RISC24_ILLEGAL_HALT_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = op_ndu ? 2'b01 : 2'b00;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = op_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        wb_sel    = 2'b01;
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 2'b10;
        pc_src    = 1'b1;
        pc_write  = bus.alu_zero;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef RISC24_ILLEGAL_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
    if (!reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = 2'b00;
      alu_ctrl  = 2'b00;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      reg_dst   = 1'b0;
      wb_sel    = 2'b00;
      illegal   = 1'b0;
    end
  end

  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.wb_sel     = wb_sel;
  assign bus.illegal    = illegal;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one task per scenario, checks inline.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int ncyc;

  always #5 clk = ~clk;

  multicycle_controller_if b();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(b));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b.opcode = 4'b0000; b.funct = 2'b00; b.alu_zero = 1'b0;
    b.alu_carry = 1'b0; b.mem_ready = 1'b1;
    reset = 1'b0;
    cyc(); cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", b.state); end
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b0) begin errors++; $display("FAIL rst_flags got C%b Z%b exp C0 Z0", b.carry_flag, b.zero_flag); end
    checks++; if (b.mem_read !== 1'b0 || b.ir_write !== 1'b0 || b.pc_write !== 1'b0) begin errors++; $display("FAIL rst_strobes got rd%b ir%b pc%b exp 0", b.mem_read, b.ir_write, b.pc_write); end
    checks++; if (b.alu_src_b !== 2'b00 || b.illegal !== 1'b0) begin errors++; $display("FAIL rst_selects got srcb%b ill%b exp 00 0", b.alu_src_b, b.illegal); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (b.mem_read !== 1'b1 || b.alu_src_b !== 2'b01 || b.ir_write !== 1'b1) begin errors++; $display("FAIL fetch_strobes got rd%b srcb%b ir%b exp 1 01 1", b.mem_read, b.alu_src_b, b.ir_write); end
  endtask

  task automatic test_add();
    b.opcode = 4'b0000; b.funct = 2'b00; b.alu_carry = 1'b1; b.alu_zero = 1'b0; b.mem_ready = 1'b1;
    cyc();
    checks++; if (b.state !== 4'd1 || b.alu_src_b !== 2'b10) begin errors++; $display("FAIL add_decode got st%0d srcb%b exp 1 10", b.state, b.alu_src_b); end
    cyc();
    checks++; if (b.state !== 4'd2 || b.alu_src_a !== 1'b1 || b.alu_src_b !== 2'b00 || b.alu_ctrl !== 2'b00) begin errors++; $display("FAIL add_exec got st%0d a%b b%b op%b exp 2 1 00 00", b.state, b.alu_src_a, b.alu_src_b, b.alu_ctrl); end
    cyc();
    checks++; if (b.state !== 4'd3 || b.reg_write !== 1'b1 || b.reg_dst !== 1'b0 || b.wb_sel !== 2'b00) begin errors++; $display("FAIL add_wb got st%0d rw%b dst%b wb%b exp 3 1 0 00", b.state, b.reg_write, b.reg_dst, b.wb_sel); end
    checks++; if (b.carry_flag !== 1'b1 || b.zero_flag !== 1'b0) begin errors++; $display("FAIL add_flags got C%b Z%b exp C1 Z0", b.carry_flag, b.zero_flag); end
    cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL add_return got %0d exp 0", b.state); end
  endtask

  task automatic test_conditional();
    // ADD sets C=0, Z=1
    b.opcode = 4'b0000; b.funct = 2'b00; b.alu_carry = 1'b0; b.alu_zero = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b1) begin errors++; $display("FAIL add2_flags got C%b Z%b exp C0 Z1", b.carry_flag, b.zero_flag); end
    // ADC with C=0 is skipped
    b.funct = 2'b10; b.alu_carry = 1'b1; b.alu_zero = 1'b0;
    cyc();
    checks++; if (b.state !== 4'd1 || b.reg_write !== 1'b0) begin errors++; $display("FAIL adc_decode got st%0d rw%b exp 1 0", b.state, b.reg_write); end
    cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL adc_skip_state got %0d exp 0", b.state); end
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b1) begin errors++; $display("FAIL adc_skip_flags got C%b Z%b exp C0 Z1", b.carry_flag, b.zero_flag); end
    // NDZ with Z=1 executes; carry must not change
    b.opcode = 4'b0010; b.funct = 2'b01;
    cyc(); cyc();
    checks++; if (b.state !== 4'd2 || b.alu_ctrl !== 2'b01) begin errors++; $display("FAIL ndz_exec got st%0d op%b exp 2 01", b.state, b.alu_ctrl); end
    cyc();
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b0) begin errors++; $display("FAIL ndz_flags got C%b Z%b exp C0 Z0", b.carry_flag, b.zero_flag); end
    cyc();
  endtask

  task automatic test_lw_stall();
    b.opcode = 4'b0100; b.funct = 2'b00; b.mem_ready = 1'b0; b.alu_zero = 1'b1; b.alu_carry = 1'b1;
    #1;
    checks++; if (b.ir_write !== 1'b0 || b.pc_write !== 1'b0 || b.mem_read !== 1'b1) begin errors++; $display("FAIL lw_fetch_stall got ir%b pc%b rd%b exp 0 0 1", b.ir_write, b.pc_write, b.mem_read); end
    ncyc = 0;
    cyc(); ncyc++; cyc(); ncyc++;
    checks++; if (b.state !== 4'd0 || b.mem_read !== 1'b1 || b.alu_src_b !== 2'b01) begin errors++; $display("FAIL lw_fetch_hold got st%0d rd%b srcb%b exp 0 1 01", b.state, b.mem_read, b.alu_src_b); end
    b.mem_ready = 1'b1;
    cyc(); ncyc++;
    cyc(); ncyc++;
    checks++; if (b.state !== 4'd4 || b.alu_src_a !== 1'b1 || b.alu_src_b !== 2'b10) begin errors++; $display("FAIL lw_addr got st%0d a%b b%b exp 4 1 10", b.state, b.alu_src_a, b.alu_src_b); end
    b.mem_ready = 1'b0;
    cyc(); ncyc++;
    cyc(); ncyc++;
    checks++; if (b.state !== 4'd5 || b.mem_read !== 1'b1 || b.ir_write !== 1'b0) begin errors++; $display("FAIL lw_memrd got st%0d rd%b ir%b exp 5 1 0", b.state, b.mem_read, b.ir_write); end
    b.mem_ready = 1'b1;
    cyc(); ncyc++;
    checks++; if (b.state !== 4'd6 || b.wb_sel !== 2'b01 || b.reg_dst !== 1'b1 || b.reg_write !== 1'b1) begin errors++; $display("FAIL lw_wb got st%0d wb%b dst%b rw%b exp 6 01 1 1", b.state, b.wb_sel, b.reg_dst, b.reg_write); end
    cyc(); ncyc++;
    checks++; if (b.state !== 4'd0 || ncyc != 8) begin errors++; $display("FAIL lw_cycles got st%0d n%0d exp 0 8", b.state, ncyc); end
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b0) begin errors++; $display("FAIL lw_flags got C%b Z%b exp C0 Z0", b.carry_flag, b.zero_flag); end
  endtask

  task automatic test_beq();
    b.opcode = 4'b1100; b.mem_ready = 1'b1;
    cyc(); cyc();
    b.alu_zero = 1'b1; #1;
    checks++; if (b.state !== 4'd8 || b.pc_write !== 1'b1 || b.pc_src !== 1'b1 || b.alu_ctrl !== 2'b10) begin errors++; $display("FAIL beq_taken got st%0d pcw%b src%b op%b exp 8 1 1 10", b.state, b.pc_write, b.pc_src, b.alu_ctrl); end
    cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL beq_taken_ret got %0d exp 0", b.state); end
    cyc(); cyc();
    b.alu_zero = 1'b0; #1;
    checks++; if (b.state !== 4'd8 || b.pc_write !== 1'b0) begin errors++; $display("FAIL beq_not_taken got st%0d pcw%b exp 8 0", b.state, b.pc_write); end
    cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL beq_nt_ret got %0d exp 0", b.state); end
  endtask

  task automatic test_jal();
    b.opcode = 4'b1000;
    cyc();
    checks++; if (b.alu_src_b !== 2'b11) begin errors++; $display("FAIL jal_decode_srcb got %b exp 11", b.alu_src_b); end
    cyc();
    checks++; if (b.state !== 4'd9 || b.reg_write !== 1'b1 || b.reg_dst !== 1'b1 || b.wb_sel !== 2'b10 || b.pc_write !== 1'b1 || b.pc_src !== 1'b1) begin errors++; $display("FAIL jal_state got st%0d rw%b dst%b wb%b pcw%b src%b exp 9 1 1 10 1 1", b.state, b.reg_write, b.reg_dst, b.wb_sel, b.pc_write, b.pc_src); end
    cyc();
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL jal_ret got %0d exp 0", b.state); end
  endtask

  task automatic test_illegal();
    // ADD with funct 11 is illegal too
    b.opcode = 4'b0000; b.funct = 2'b11;
    cyc();
    checks++; if (b.illegal !== 1'b1) begin errors++; $display("FAIL ill_funct11 got %b exp 1", b.illegal); end
`ifdef RISC24_ILLEGAL_HALT_EN
    cyc();
    reset = 1'b0; #1; reset = 1'b1;
`else
    cyc();
`endif
    b.opcode = 4'b1111; b.funct = 2'b00;
    cyc();
    checks++; if (b.state !== 4'd1 || b.illegal !== 1'b1) begin errors++; $display("FAIL ill_decode got st%0d ill%b exp 1 1", b.state, b.illegal); end
    cyc();
    checks++; if (b.illegal !== 1'b0) begin errors++; $display("FAIL ill_pulse_width got %b exp 0", b.illegal); end
`ifdef RISC24_ILLEGAL_HALT_EN
    for (int i = 0; i < 10; i++) begin
      checks++; if (b.state !== 4'd15 || b.mem_read !== 1'b0 || b.pc_write !== 1'b0) begin errors++; $display("FAIL halt_hold cyc%0d got st%0d rd%b pcw%b exp 15 0 0", i, b.state, b.mem_read, b.pc_write); end
      cyc();
    end
    reset = 1'b0; #1; reset = 1'b1;
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL halt_reset got %0d exp 0", b.state); end
`else
    checks++; if (b.state !== 4'd0) begin errors++; $display("FAIL ill_nop got %0d exp 0", b.state); end
`endif
  endtask

  task automatic test_sw_reset();
    b.opcode = 4'b0000; b.funct = 2'b00; b.alu_carry = 1'b1; b.alu_zero = 1'b1; b.mem_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    checks++; if (b.carry_flag !== 1'b1 || b.zero_flag !== 1'b1) begin errors++; $display("FAIL pre_sw_flags got C%b Z%b exp C1 Z1", b.carry_flag, b.zero_flag); end
    b.opcode = 4'b0101;
    cyc(); cyc();
    b.mem_ready = 1'b0;
    cyc();
    checks++; if (b.state !== 4'd7 || b.mem_write !== 1'b1) begin errors++; $display("FAIL sw_memwr got st%0d wr%b exp 7 1", b.state, b.mem_write); end
    cyc();
    checks++; if (b.state !== 4'd7 || b.mem_write !== 1'b1) begin errors++; $display("FAIL sw_stall got st%0d wr%b exp 7 1", b.state, b.mem_write); end
    #2 reset = 1'b0; #1;
    checks++; if (b.mem_write !== 1'b0 || b.state !== 4'd0) begin errors++; $display("FAIL sw_abort got wr%b st%0d exp 0 0", b.mem_write, b.state); end
    checks++; if (b.carry_flag !== 1'b0 || b.zero_flag !== 1'b0) begin errors++; $display("FAIL sw_abort_flags got C%b Z%b exp C0 Z0", b.carry_flag, b.zero_flag); end
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_conditional();
    test_lw_stall();
    test_beq();
    test_jal();
    test_illegal();
    test_sw_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
